// File: rtl/byte_avg_sequencer.sv
// Byte averaging sequencer: captures a word, streams its bytes LSB-first under
// a valid/ready handshake, accumulates their sum and reports the truncated average.
module byte_avg_sequencer #(
  parameter int NBYTES = 8,
  parameter int BW     = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           abort,
  input  logic [NBYTES*BW-1:0]           data_stream,
  input  logic                           byte_ready,
  output logic                           byte_valid,
  output logic [BW-1:0]                  q,
  output logic [7:0]                     count,
  output logic                           busy,
  output logic [BW+$clog2(NBYTES)-1:0]   sum,
  output logic [BW-1:0]                  avg,
  output logic                           done
);

  localparam int LG = $clog2(NBYTES);
  localparam int SW = BW + LG;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [NBYTES*BW-1:0]  r_data;
  logic [7:0]            r_count;
  logic [SW-1:0]         r_sum;
  logic [BW-1:0]         r_avg;

  logic [BW-1:0]         w_bytes [NBYTES];
  logic [BW-1:0]         w_byte;
  logic                  w_xfer;
  logic                  w_last;
  logic [SW-1:0]         w_sum_add;

  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_byte
      assign w_bytes[gi] = r_data[gi*BW +: BW];
    end
  endgenerate

  assign w_byte    = w_bytes[r_count[LG-1:0]];
  // abort beats a coincident handshake, so the byte is never counted
  assign w_xfer    = (r_state == S_SHIFT) && byte_ready && !abort;
  assign w_last    = (r_count == 8'(NBYTES - 1));
  assign w_sum_add = r_sum + SW'(w_byte);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (abort) begin
          w_state_next = S_IDLE;
        end else if (w_xfer && w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_count <= '0;
      r_sum   <= '0;
      r_avg   <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_data  <= data_stream;
      r_count <= '0;
      r_sum   <= '0;
    end else if (w_xfer) begin
      r_sum   <= w_sum_add;
      r_count <= r_count + 8'd1;
      if (w_last) r_avg <= w_sum_add[SW-1:LG];
    end
  end

  // Outputs decode from state and count only; byte_ready never reaches byte_valid.
  assign byte_valid = (r_state == S_SHIFT);
  assign q          = byte_valid ? w_byte : '0;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign count      = r_count;
  assign sum        = r_sum;
  assign avg        = r_avg;

endmodule

// File: tb/tb_byte_avg_sequencer.sv
// Directed bench for byte_avg_sequencer: expected bytes and results are queued
// when a word is started and compared as the DUT streams bytes and signals done.
module tb_byte_avg_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [63:0] data_stream;
  logic        byte_ready;
  logic        byte_valid;
  logic [7:0]  q;
  logic [7:0]  count;
  logic        busy;
  logic [10:0] sum;
  logic [7:0]  avg;
  logic        done;

  int total = 0;
  int bad   = 0;

  logic [7:0]  exp_q  [$];
  logic [10:0] sb_sum [$];
  logic [7:0]  sb_avg [$];

  localparam logic [63:0] W1 = 64'h0807060504030201;
  localparam logic [63:0] WF = 64'hFFFFFFFFFFFFFFFF;
  localparam logic [63:0] WT = 64'hF0CEFC0BF0CEFC05;

  byte_avg_sequencer #(.NBYTES(8), .BW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .data_stream(data_stream),
    .byte_ready (byte_ready),
    .byte_valid (byte_valid),
    .q          (q),
    .count      (count),
    .busy       (busy),
    .sum        (sum),
    .avg        (avg),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts word d; byte_ready drops for stall_len cycles once count reaches stall_at.
  task automatic run_word(input logic [63:0] d, input int stall_at, input int stall_len,
                          input int exp_lat, input logic [10:0] exp_sum, input logic [7:0] exp_avg);
    int          cyc;
    int          stalled;
    bit          got;
    logic [10:0] psum;
    logic [7:0]  b;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      b = d[i*8 +: 8];
      exp_q.push_back(b);
    end
    sb_sum.push_back(exp_sum);
    sb_avg.push_back(exp_avg);
    start = 1'b1;
    data_stream = d;
    byte_ready = 1'b1;
    step();
    start = 1'b0;
    data_stream = ~d;
    chk("busy_after_start", busy, 1);
    chk("count_cleared", count, 0);
    cyc = 1;
    stalled = 0;
    got = 1'b0;
    psum = '0;
    while (cyc <= 40 && !got) begin
      if (done) begin
        got = 1'b1;
        chk("done_latency", cyc, exp_lat);
        chk("final_sum", sum, sb_sum.pop_front());
        chk("final_avg", avg, sb_avg.pop_front());
        chk("final_count", count, 8);
        chk("done_valid_low", byte_valid, 0);
        chk("done_busy", busy, 1);
      end else begin
        chk("running_sum", sum, psum);
        byte_ready = !(int'(count) == stall_at && stalled < stall_len);
        if (!byte_ready) begin
          stalled++;
          chk("stall_q_hold", q, exp_q[0]);
        end
        if (byte_valid && byte_ready && exp_q.size() > 0) begin
          b = exp_q.pop_front();
          chk("q_byte", q, b);
          psum = psum + 11'(b);
        end
        step();
        cyc++;
      end
    end
    if (!got) chk("done_timeout", 0, 1);
    byte_ready = 1'b1;
    step();
    chk("done_single", done, 0);
    chk("idle_after_done", busy, 0);
    chk("sum_held", sum, exp_sum);
    chk("avg_held", avg, exp_avg);
    chk("count_held", count, 8);
  endtask

  initial begin
    logic [7:0] b;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    data_stream = '0;
    byte_ready = 1'b0;
    step();
    step();
    chk("rst_valid", byte_valid, 0);
    chk("rst_q", q, 0);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_avg", avg, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    step();

    run_word(W1, -1, 0, 9, 11'd36, 8'd4);
    run_word(WF, -1, 0, 9, 11'd2040, 8'd255);
    run_word(W1, 2, 3, 12, 11'd36, 8'd4);
    // byte sum of WT is 1412; 1412/8 = 176.5 truncates to 176
    run_word(WT, -1, 0, 9, 11'd1412, 8'd176);

    // abort at count=4 with a coincident handshake
    start = 1'b1;
    data_stream = W1;
    byte_ready = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20 && count != 8'd4; i++) begin
      chk("abort_no_done_run", done, 0);
      step();
    end
    chk("abort_reach_cnt4", count, 4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_idle", busy, 0);
    chk("abort_valid", byte_valid, 0);
    chk("abort_done", done, 0);
    chk("abort_count", count, 4);
    chk("abort_sum", sum, 10);
    chk("abort_avg", avg, 176);
    run_word(W1, -1, 0, 9, 11'd36, 8'd4);

    // extra start while busy, then reset mid-word
    start = 1'b1;
    data_stream = W1;
    byte_ready = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20 && count != 8'd2; i++) step();
    start = 1'b1;
    data_stream = WF;
    step();
    start = 1'b0;
    chk("busy_start_count", count, 3);
    b = W1[31:24];
    chk("busy_start_q", q, b);
    chk("busy_start_sum", sum, 6);
    for (int i = 0; i < 20 && count != 8'd5; i++) begin
      chk("pre_rst_no_done", done, 0);
      step();
    end
    chk("pre_rst_cnt5", count, 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_valid", byte_valid, 0);
    chk("midrst_q", q, 0);
    chk("midrst_count", count, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_avg", avg, 0);
    chk("midrst_done", done, 0);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("post_rst_no_done", done, 0);
    end
    chk("post_rst_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
